// File: rtl/pdua_ctrl_pkg.sv
// pdua_ctrl_pkg: shared states, opcodes, ALU codes, register addresses and opcode decode for the PDUA control unit
package pdua_ctrl_pkg;
  typedef enum logic [3:0] {INIT, F0, F1, F2, DEC, EXA, EXJ, EXI, S0, S1, S2, HALT} state_t;
  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_MOV_AT = 5'b00001;
  localparam logic [4:0] OP_MOV_TA = 5'b00010;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_AND    = 5'b00100;
  localparam logic [4:0] OP_NOT    = 5'b00101;
  localparam logic [4:0] OP_ST     = 5'b00110;
  localparam logic [4:0] OP_JZ     = 5'b00111;
  localparam logic [4:0] OP_JN     = 5'b01000;
  localparam logic [4:0] OP_HALT   = 5'b11111;
  localparam logic [2:0] SEL_PASS = 3'b000;
  localparam logic [2:0] SEL_AND  = 3'b001;
  localparam logic [2:0] SEL_OR   = 3'b010;
  localparam logic [2:0] SEL_NOT  = 3'b011;
  localparam logic [2:0] SEL_ADD  = 3'b100;
  localparam logic [2:0] SEL_INC  = 3'b110;
  localparam logic [2:0] R_PC   = 3'd0;
  localparam logic [2:0] R_DPTR = 3'd2;
  localparam logic [2:0] R_ACC  = 3'd3;
  localparam logic [2:0] R_TMP  = 3'd7;
  function automatic state_t dec_state(input logic [4:0] op);
    case (op)
      OP_NOP:                                      return F0;
      OP_MOV_AT, OP_MOV_TA, OP_ADD, OP_AND, OP_NOT: return EXA;
      OP_ST:                                       return S0;
      OP_JZ, OP_JN:                                return EXJ;
      OP_HALT:                                     return HALT;
      default:                                     return EXI;
    endcase
  endfunction
endpackage

// File: rtl/pdua_wait_counter.sv
// pdua_wait_counter: 4-bit loadable down-counter (load_i/val_i load, en_i decrement, zero_o at 0)
module pdua_wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       en_i,
  input  logic [3:0] val_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;
  assign zero_o = cnt_q == 4'd0;
  assign cnt_d = load_i ? val_i : (en_i && !zero_o) ? cnt_q - 4'd1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pdua_ctrl_unit.sv
// pdua_ctrl_unit: PDUA fetch/decode/execute FSM; in clk/rst/opcode/C,N,P,Z, out datapath controls plus halted/illegal
module pdua_ctrl_unit
  import pdua_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 5,
  parameter int WAIT_STATES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    C,
  input  logic                    N,
  input  logic                    P,
  input  logic                    Z,
  output logic                    wr_rdn,
  output logic                    enaf,
  output logic [2:0]              selop,
  output logic [1:0]              shamt,
  output logic                    bank_wr_en,
  output logic [ADDR_WIDTH-1:0]   BusB_addr,
  output logic [ADDR_WIDTH-1:0]   BusC_addr,
  output logic                    sclr,
  output logic                    ir_en,
  output logic                    mar_en,
  output logic                    mdr_en,
  output logic                    mdr_alu_n,
  output logic                    halted,
  output logic                    illegal
);
  localparam logic [ADDR_WIDTH-1:0] A_PC   = ADDR_WIDTH'(R_PC);
  localparam logic [ADDR_WIDTH-1:0] A_DPTR = ADDR_WIDTH'(R_DPTR);
  localparam logic [ADDR_WIDTH-1:0] A_ACC  = ADDR_WIDTH'(R_ACC);
  localparam logic [ADDR_WIDTH-1:0] A_TMP  = ADDR_WIDTH'(R_TMP);
  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       wz, op_fits, take, unused_flags;
  assign unused_flags = C ^ P;
  // opcodes wider than the ISA are legal only when their upper bits are zero
  assign op_fits = opcode == OPCODE_WIDTH'(opcode[4:0]);
  assign op_d = state_q == DEC ? opcode[4:0] : op_q;
  assign take = op_q == OP_JZ ? Z : N;
  assign shamt = 2'b00;
  pdua_wait_counter u_wait (
    .clk    (clk),
    .rst    (rst),
    .load_i (state_q == F0 || state_q == S1),
    .en_i   (state_q == F1 || state_q == S2),
    .val_i  (4'(WAIT_STATES)),
    .zero_o (wz)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= INIT;
      op_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:          state_d = F0;
      F0:            state_d = F1;
      F1:            state_d = wz ? F2 : F1;
      F2:            state_d = DEC;
      DEC:           state_d = op_fits ? dec_state(opcode[4:0]) : EXI;
      EXA, EXJ, EXI: state_d = F0;
      S0:            state_d = S1;
      S1:            state_d = S2;
      S2:            state_d = wz ? F0 : S2;
      default:       state_d = state_q;
    endcase
  end
  always_comb begin
    wr_rdn     = 1'b0;
    enaf       = 1'b0;
    selop      = SEL_PASS;
    bank_wr_en = 1'b0;
    BusB_addr  = '0;
    BusC_addr  = '0;
    sclr       = 1'b0;
    ir_en      = 1'b0;
    mar_en     = 1'b0;
    mdr_en     = 1'b0;
    mdr_alu_n  = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      INIT: sclr = 1'b1;
      F0: begin
        BusB_addr = A_PC;
        mar_en    = 1'b1;
      end
      F1: begin
        mdr_alu_n  = 1'b1;
        mdr_en     = wz;
        bank_wr_en = wz;
        selop      = wz ? SEL_INC : SEL_PASS;
        BusB_addr  = A_PC;
        BusC_addr  = A_PC;
      end
      F2: ir_en = 1'b1;
      EXA: begin
        BusB_addr  = op_q == OP_MOV_TA ? A_ACC : A_TMP;
        BusC_addr  = op_q == OP_MOV_TA ? A_TMP : A_ACC;
        selop      = op_q == OP_ADD ? SEL_ADD : op_q == OP_AND ? SEL_AND : op_q == OP_NOT ? SEL_NOT : SEL_PASS;
        enaf       = op_q == OP_ADD || op_q == OP_AND || op_q == OP_NOT;
        bank_wr_en = 1'b1;
      end
      EXJ: begin
        BusB_addr  = take ? A_DPTR : '0;
        BusC_addr  = A_PC;
        bank_wr_en = take;
      end
      EXI: illegal = 1'b1;
      S0: begin
        BusB_addr = A_DPTR;
        mar_en    = 1'b1;
      end
      S1: begin
        BusB_addr = A_ACC;
        mdr_en    = 1'b1;
      end
      S2: wr_rdn = 1'b1;
      HALT: halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_pdua_ctrl_unit.sv
// tb_pdua_ctrl_unit: directed checks of the PDUA control unit with zero and two memory wait states
module tb_pdua_ctrl_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] opcode = 5'b00001;
  logic       C = 1'b0, N = 1'b0, P = 1'b0, Z = 1'b0;
  wire [20:0] o0, o2;
  int         total = 0, bad = 0;
  logic [20:0] init_v, f0_v, f1n_v, f1l_v, f2_v, s0_v, s1_v, s2_v, halt_v, ill_v;
  always #5 clk = ~clk;
  pdua_ctrl_unit #(.ADDR_WIDTH(3), .OPCODE_WIDTH(5), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .opcode(opcode), .C(C), .N(N), .P(P), .Z(Z),
    .wr_rdn(o0[20]), .enaf(o0[19]), .selop(o0[18:16]), .shamt(o0[15:14]), .bank_wr_en(o0[13]),
    .BusB_addr(o0[12:10]), .BusC_addr(o0[9:7]), .sclr(o0[6]), .ir_en(o0[5]), .mar_en(o0[4]),
    .mdr_en(o0[3]), .mdr_alu_n(o0[2]), .halted(o0[1]), .illegal(o0[0])
  );
  pdua_ctrl_unit #(.ADDR_WIDTH(3), .OPCODE_WIDTH(5), .WAIT_STATES(2)) u2 (
    .clk(clk), .rst(rst), .opcode(opcode), .C(C), .N(N), .P(P), .Z(Z),
    .wr_rdn(o2[20]), .enaf(o2[19]), .selop(o2[18:16]), .shamt(o2[15:14]), .bank_wr_en(o2[13]),
    .BusB_addr(o2[12:10]), .BusC_addr(o2[9:7]), .sclr(o2[6]), .ir_en(o2[5]), .mar_en(o2[4]),
    .mdr_en(o2[3]), .mdr_alu_n(o2[2]), .halted(o2[1]), .illegal(o2[0])
  );
  function automatic logic [20:0] v(logic wr, logic ef, logic [2:0] sel, logic bk, logic [2:0] b,
                                    logic [2:0] c, logic sc, logic ir, logic mar, logic mdr,
                                    logic mam, logic h, logic il);
    return {wr, ef, sel, 2'b00, bk, b, c, sc, ir, mar, mdr, mam, h, il};
  endfunction
  task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  task automatic fetch0(input string tag);
    step(); chk({tag, "_f0"}, o0, f0_v);
    step(); chk({tag, "_f1"}, o0, f1l_v);
    step(); chk({tag, "_f2"}, o0, f2_v);
    step(); chk({tag, "_dec"}, o0, 21'd0);
  endtask
  initial begin
    logic [4:0]  alu_op [5];
    logic [20:0] alu_ex [5];
    logic [20:0] st_ex [12];
    int          wr_cnt;
    init_v = v(0,0,3'd0,0,3'd0,3'd0,1,0,0,0,0,0,0);
    f0_v   = v(0,0,3'd0,0,3'd0,3'd0,0,0,1,0,0,0,0);
    f1n_v  = v(0,0,3'd0,0,3'd0,3'd0,0,0,0,0,1,0,0);
    f1l_v  = v(0,0,3'd6,1,3'd0,3'd0,0,0,0,1,1,0,0);
    f2_v   = v(0,0,3'd0,0,3'd0,3'd0,0,1,0,0,0,0,0);
    s0_v   = v(0,0,3'd0,0,3'd2,3'd0,0,0,1,0,0,0,0);
    s1_v   = v(0,0,3'd0,0,3'd3,3'd0,0,0,0,1,0,0,0);
    s2_v   = v(1,0,3'd0,0,3'd0,3'd0,0,0,0,0,0,0,0);
    halt_v = v(0,0,3'd0,0,3'd0,3'd0,0,0,0,0,0,1,0);
    ill_v  = v(0,0,3'd0,0,3'd0,3'd0,0,0,0,0,0,0,1);
    alu_op = '{5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101};
    alu_ex = '{v(0,0,3'd0,1,3'd7,3'd3,0,0,0,0,0,0,0), v(0,0,3'd0,1,3'd3,3'd7,0,0,0,0,0,0,0),
               v(0,1,3'd4,1,3'd7,3'd3,0,0,0,0,0,0,0), v(0,1,3'd1,1,3'd7,3'd3,0,0,0,0,0,0,0),
               v(0,1,3'd3,1,3'd7,3'd3,0,0,0,0,0,0,0)};
    #2 rst = 1'b1;
    #1 chk("rst_async_w0", o0, init_v);
    chk("rst_async_w2", o2, init_v);
    step(); chk("rst_hold", o0, init_v);
    rst = 1'b0;
    fetch0("mov");
    step(); chk("mov_exa", o0, alu_ex[0]);
    opcode = 5'b11111;
    step(); chk("mov_back_f0", o0, f0_v);
    for (int i = 0; i < 5; i++) begin
      opcode = alu_op[i];
      do_reset();
      fetch0("alu");
      step(); chk($sformatf("alu_exa_op%0d", i), o0, alu_ex[i]);
    end
    opcode = 5'b00000;
    do_reset();
    fetch0("nop");
    step(); chk("nop_f0", o0, f0_v);
    for (int i = 0; i < 4; i++) begin
      logic f;
      f = i[0];
      opcode = i < 2 ? 5'b00111 : 5'b01000;
      Z = 1'b0; N = 1'b0;
      do_reset();
      fetch0("jmp");
      if (i < 2) begin Z = f; N = ~f; end
      else begin N = f; Z = ~f; end
      step(); chk($sformatf("jmp_exj_%0d", i), o0, f ? v(0,0,3'd0,1,3'd2,3'd0,0,0,0,0,0,0,0) : 21'd0);
      step(); chk($sformatf("jmp_f0_%0d", i), o0, f0_v);
    end
    Z = 1'b0; N = 1'b0;
    opcode = 5'b10101;
    do_reset();
    fetch0("ill");
    step(); chk("ill_pulse", o0, ill_v);
    step(); chk("ill_next_f0", o0, f0_v);
    opcode = 5'b11111;
    do_reset();
    fetch0("halt");
    for (int i = 0; i < 20; i++) begin
      step(); chk($sformatf("halt_%0d", i), o0, halt_v);
    end
    rst = 1'b1;
    #1 chk("halt_rst_init", o0, init_v);
    step(); rst = 1'b0;
    step(); chk("halt_rst_f0", o0, f0_v);
    st_ex = '{f0_v, f1n_v, f1n_v, f1l_v, f2_v, 21'd0, s0_v, s1_v, s2_v, s2_v, s2_v, f0_v};
    opcode = 5'b00110;
    do_reset();
    wr_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(); chk($sformatf("st_w2_c%0d", i + 1), o2, st_ex[i]);
      wr_cnt += int'(o2[20]);
    end
    chk("st_w2_wr_cycles", 21'(wr_cnt), 21'd3);
    do_reset();
    for (int i = 0; i < 9; i++) step();
    chk("st_rst_in_s2", o2, s2_v);
    rst = 1'b1;
    #1 chk("st_rst_wr_drop", 21'(o2[20]), 21'd0);
    chk("st_rst_init", o2, init_v);
    step(); rst = 1'b0;
    step(); chk("st_rst_f0", o2, f0_v);
    step(); chk("st_rst_f1", o2, f1n_v);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pdua_ctrl_unit.md
# pdua_ctrl_unit

Parametrised hardwired control unit for the PDUA datapath. It replaces hand-driven control vectors with a fetch/decode/execute state machine. It consumes the IR opcode and the C/N/P/Z flags, and drives every datapath control input (bank addresses, ALU op, register enables, memory direction). It adds configurable memory wait states and conditional jumps, which the hand-sequenced datapath does not have.

## Interface
- ADDR_WIDTH, 3: register-bank address width; must be ≥3.
- OPCODE_WIDTH, 5: IR opcode width; must be ≥5.
- WAIT_STATES, 0: extra cycles per memory access, 0..15.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  OPCODE_WIDTH  IR output (out_IR)
- C, N, P, Z  in  1 each  ALU flags
- wr_rdn  out  1  memory direction: 1 = write, 0 = read
- enaf  out  1  flag-register update enable
- selop  out  3  ALU operation
- shamt  out  2  shift amount (always 0 in this ISA)
- bank_wr_en  out  1  register-bank write enable
- BusB_addr, BusC_addr  out  ADDR_WIDTH  source / destination register
- sclr, ir_en, mar_en, mdr_en  out  1  IR/MAR/MDR clear and enables
- mdr_alu_n  out  1  MDR input select: 1 = memory, 0 = ALU
- halted  out  1  high in the HALT state
- illegal  out  1  one-cycle pulse on an unknown opcode

## Operation
- **Shared constants**
  - Registers: PC=0, DPTR=2, ACC=3, TMP=7, zero-extended to ADDR_WIDTH.
  - selop codes: PASS=000, AND=001, OR=010, NOT=011, ADD=100, INC=110.
- **Outputs**
  - Outputs are decoded combinationally from the state, plus Z/N in the jump states.
  - Any output not listed for a state is 0.
- **INIT**
  - sclr=1.
  - Next state: F0.
- **F0**
  - BusB=PC, selop=PASS, mar_en=1.
- **F1**
  - wr_rdn=0, mdr_alu_n=1.
  - Holds for WAIT_STATES+1 cycles.
  - On the final cycle only: mdr_en=1, and PC←PC+1 (BusB=BusC=PC, selop=INC, bank_wr_en=1).
- **F2**
  - ir_en=1.
- **DEC**
  - No outputs.
  - Branches on opcode.
- **Opcodes and execute states**
  - 00000 NOP: back to F0.
  - 00001 MOV ACC←TMP (EXA): BusB=TMP, BusC=ACC, PASS, bank_wr_en=1.
  - 00010 MOV TMP←ACC: as EXA with BusB and BusC swapped.
  - 00011 ADD, 00100 AND, 00101 NOT (EXA): BusB=TMP, BusC=ACC, selop per opcode, enaf=1, bank_wr_en=1.
  - 00110 ST [DPTR]←ACC:
    - S0: BusB=DPTR, PASS, mar_en=1.
    - S1: BusB=ACC, PASS, mdr_en=1, mdr_alu_n=0.
    - S2: wr_rdn=1 for WAIT_STATES+1 cycles.
  - 00111 JZ, 01000 JN (EXJ): if Z (resp. N)=1, then BusB=DPTR, BusC=PC, PASS, bank_wr_en=1; otherwise no outputs.
  - 11111 HALT: enter HALT; halted=1; all controls 0; leave only on rst.
  - Any other opcode: illegal=1 for one cycle (EXI), then behaves as NOP.
- **Transitions**
  - After every EX*/S2 completion, next state is F0.

## Timing
- **During rst**
  - State is INIT: sclr=1; every other output, including the buses, is 0.
- **Leaving reset**
  - The first edge after rst deasserts moves to F0.
- **Cycle counts (W = WAIT_STATES)**
  - Fetch: 3+W cycles.
  - DEC: 1 cycle.
  - MOV/ALU/jump/illegal: 1 cycle; total 5+W.
  - NOP: total 4+W.
  - ST: 3+W cycles; total 7+2W.
- **Wait counter**
  - Loads WAIT_STATES on entry to F1/S2.
  - Decrements each cycle and exits at 0.
  - With W=0, F1 and S2 last exactly one cycle.
- **Jump flags**
  - Sampled in the EXJ cycle. They reflect the last enaf=1 update, not the fetch-time value.
- **Reset mid-operation**
  - INIT is entered immediately, without waiting for an edge.
  - wr_rdn drops combinationally, even mid-store.
  - The wait counter clears.
- **Opcode sampling**
  - Opcode is sampled only in DEC. Changes at other times are ignored.

## Structure
- **Package pdua_ctrl_pkg**
  - State enum: INIT, F0, F1, F2, DEC, EXA, EXJ, EXI, S0, S1, S2, HALT.
  - Opcode constants.
  - selop constants.
  - Register-address constants.
- **Sub-module pdua_wait_counter**
  - 4-bit loadable down-counter with load, en and zero outputs.
  - Instantiated once; shared by F1 and S2.

## Test plan
- **Reset then MOV, W=0**
  - Stimulus: opcode 00001.
  - Required: sclr=1 during rst; F0 mar_en on cycle 1; F1 mdr_en+INC; F2 ir_en; EXA BusB=7, BusC=3, selop=000, bank_wr_en=1 on cycle 5; back to F0 on cycle 6.
- **ST with WAIT_STATES=2**
  - Required: F1 lasts 3 cycles, with mdr_en only on the 3rd; wr_rdn=1 for exactly 3 cycles; total 11 cycles.
- **JZ, both flag values**
  - With Z=1: EXJ writes PC from DPTR (BusC=0, BusB=2, bank_wr_en=1).
  - With Z=0: bank_wr_en=0.
  - Repeat for JN with N.
- **Illegal opcode 10101**
  - Required: one illegal pulse in the cycle after DEC; no enables asserted; next fetch follows.
- **HALT 11111**
  - Required: halted=1 held for 20 cycles with all controls 0; rst returns to INIT.
- **rst asserted during S2**
  - Required: wr_rdn falls to 0 combinationally; after release, F0 follows the INIT cycle.
